cumsum_exclusive_sequencer: RTL

- Controller for the exclusive cumulative-sum datapath. Accepts a job descriptor giving rows × row length, then consumes a row-major element stream.
- Emits each element's exclusive prefix sum along the row dimension, clearing the accumulator at every row boundary and flagging row ends.
- Sits between the tensor stream fabric and downstream consumers. Owns job sequencing, the row/column counters and the shared accumulator.

---
 rtl/cumsum_pkg.sv | 19 +
 rtl/cumsum_scan_row_counter.sv | 40 ++++
 rtl/cumsum_exclusive_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/cumsum_pkg.sv
// Shared types and defaults for the exclusive cumulative-sum sequencer.
// Holds the FSM state encoding and the job descriptor layout.
package cumsum_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] rows;
    logic [CNT_W_DEF-1:0] len;
  } desc_t;

endpackage

// File: rtl/cumsum_scan_row_counter.sv
// Column/row position tracker for a row-major scan; flags the row end and job end.
// Combinational flags from registered counters; advances only on step.
module cumsum_scan_row_counter
  import cumsum_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [CNT_W-1:0] rows,
  input  logic [CNT_W-1:0] len,
  output logic             row_end,
  output logic             job_end
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] row_q;

  assign row_end = (col_q == len - ONE);
  assign job_end = row_end && (row_q == rows - ONE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (step) begin
      if (row_end) begin
        col_q <= '0;
        row_q <= row_q + ONE;
      end else begin
        col_q <= col_q + ONE;
      end
    end
  end

endmodule

// File: rtl/cumsum_exclusive_sequencer.sv
// Job sequencer emitting per-row exclusive prefix sums of a row-major stream.
// Latency: 1 cycle accept-to-out_valid; single output register, full throughput.
// Backpressure: in_ready drops while the output register is full and not draining.
module cumsum_exclusive_sequencer
  import cumsum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_rows,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t            state_q;
  state_t            state_nxt;
  desc_t             desc_q;
  logic [DATA_W-1:0] acc_q;
  logic              row_end;
  logic              job_end;

  logic fields_ok;
  logic start;
  logic accept;
  logic out_free;

  assign fields_ok = (cfg_rows != '0) && (cfg_len != '0);
  assign start     = (state_q == IDLE) && cfg_valid && fields_ok;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_valid || out_ready;

  cumsum_scan_row_counter #(
    .CNT_W (CNT_W)
  ) u_row_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .step    (accept),
    .rows    (desc_q.rows),
    .len     (desc_q.len),
    .row_end (row_end),
    .job_end (job_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // DRAIN holds one extra cycle so done is seen before cfg_ready returns.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && job_end) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == IDLE);
    in_ready  = (state_q == RUN) && out_free;
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q    <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= (state_q == IDLE) && cfg_valid && !fields_ok;
      done    <= (state_q == DRAIN) && !done && out_free;

      if (start) begin
        desc_q.rows <= cfg_rows;
        desc_q.len  <= cfg_len;
        acc_q       <= '0;
      end else if (accept) begin
        // The row's final element never contributes to any emitted sum.
        acc_q <= row_end ? '0 : acc_q + in_data;
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= acc_q;
        out_last  <= row_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
